// File: rtl/scan_seq_pkg.sv
// Shared types and helpers for the scan sequencer: FSM state encoding and
// a next-set-bit priority search over a channel mask.
package scan_seq_pkg;

  localparam int unsigned MAX_CH = 32;
  localparam int unsigned IDX_W  = 5;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } next_bit_t;

  // Lowest set bit of mask at or above position 'from'; scanning downwards
  // lets the last hit win, so no early exit is needed.
  function automatic next_bit_t next_set_bit(input logic [MAX_CH-1:0] mask,
                                             input int unsigned from);
    next_bit_t r;
    r = '0;
    for (int unsigned i = MAX_CH; i > 0; i--) begin
      if ((i - 1) >= from && mask[i-1]) begin
        r.found = 1'b1;
        r.idx   = IDX_W'(i - 1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Settle-time counter: cleared by clr, advanced by en, tc flags the last
// settle cycle of a channel.
module seq_timer #(
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned TW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [TW-1:0] LAST = TW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + TW'(1);
    end
  end

  assign tc = (SETTLE_CYCLES == 0) || (count == LAST);

endmodule

// File: rtl/scan_sequencer.sv
// Steps through the channels of a latched mask, waiting a settle time on
// each and then running a req/ack sample handshake with the datapath.
module scan_sequencer
  import scan_seq_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CH_W          = $clog2(NUM_CH),
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned CNT_W         = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [CH_W-1:0]   ch_sel,
  output logic              sample_req,
  input  logic              sample_ack,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  scan_count
);

  state_t            state;
  logic [NUM_CH-1:0] mask_q;
  logic              timer_clr;
  logic              timer_en;
  logic              timer_tc;
  next_bit_t         first_bit;
  next_bit_t         next_bit;

  assign first_bit = next_set_bit(MAX_CH'(ch_mask), 0);
  assign next_bit  = next_set_bit(MAX_CH'(mask_q), 32'(ch_sel) + 32'd1);

  // Timer is held clear whenever it is not counting, so every entry to
  // SETTLE starts from zero without a dedicated entry strobe.
  assign timer_clr = (state == IDLE) || (state == SAMPLE);
  assign timer_en  = (state == SETTLE);

  seq_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (timer_clr),
    .en   (timer_en),
    .tc   (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      mask_q     <= '0;
      ch_sel     <= '0;
      sample_req <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      scan_count <= '0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        state      <= IDLE;
        busy       <= 1'b0;
        sample_req <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && first_bit.found) begin
              mask_q <= ch_mask;
              ch_sel <= CH_W'(first_bit.idx);
              busy   <= 1'b1;
              if (SETTLE_CYCLES == 0) begin
                state      <= SAMPLE;
                sample_req <= 1'b1;
              end else begin
                state <= SETTLE;
              end
            end
          end
          SETTLE: begin
            if (timer_tc) begin
              state      <= SAMPLE;
              sample_req <= 1'b1;
            end
          end
          SAMPLE: begin
            if (sample_ack) begin
              if (next_bit.found) begin
                ch_sel <= CH_W'(next_bit.idx);
                if (SETTLE_CYCLES != 0) begin
                  state      <= SETTLE;
                  sample_req <= 1'b0;
                end
              end else begin
                state      <= DONE;
                sample_req <= 1'b0;
                done       <= 1'b1;
              end
            end
          end
          DONE: begin
            // Count on leaving DONE so an abort seen in DONE suppresses it.
            state      <= IDLE;
            busy       <= 1'b0;
            scan_count <= scan_count + CNT_W'(1);
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench: table-driven and randomized scans against a
// channel-list model, plus hand sequences for reset, abort and zero settle.
`timescale 1ns/1ps
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, sample_ack = 1'b0;
  logic [3:0] ch_mask = '0;
  logic [1:0] ch_sel;
  logic       sample_req, busy, done;
  logic [3:0] scan_count;

  logic       z_start = 1'b0, z_abort = 1'b0, z_ack = 1'b0;
  logic [3:0] z_mask = '0;
  logic [1:0] z_ch;
  logic       z_req, z_busy, z_done;
  logic [3:0] z_count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [3:0]  exp_count = '0;

  always #500 clk = ~clk;

  scan_sequencer #(.NUM_CH(4), .SETTLE_CYCLES(3), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ch_mask(ch_mask),
    .ch_sel(ch_sel), .sample_req(sample_req), .sample_ack(sample_ack),
    .busy(busy), .done(done), .scan_count(scan_count));

  scan_sequencer #(.NUM_CH(4), .SETTLE_CYCLES(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(z_start), .abort(z_abort), .ch_mask(z_mask),
    .ch_sel(z_ch), .sample_req(z_req), .sample_ack(z_ack),
    .busy(z_busy), .done(z_done), .scan_count(z_count));

  typedef struct {
    logic [3:0]  mask;
    int unsigned dly;
    bit          stray;
    int unsigned abort_mode;
    int unsigned abort_ord;
    logic [7:0]  exp_chs;
    int unsigned exp_n;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: channels are visited in ascending order of set mask bits.
  function automatic void ref_chs(input logic [3:0] m, output logic [7:0] c,
                                  output int unsigned n);
    n = 0;
    c = '0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        c[2*n +: 2] = 2'(i);
        n++;
      end
    end
  endfunction

  // abort_mode: 0 none, 1 abort with ack on sample ordinal abort_ord, 2 abort in DONE
  task automatic do_scan(input logic [3:0] m, input int unsigned dly, input bit stray,
                         input int unsigned abort_mode, input int unsigned abort_ord,
                         input logic [7:0] exp_chs, input int unsigned exp_n);
    int unsigned got_q[$];
    int unsigned low, ord, lim;
    logic [1:0]  held;
    logic [7:0]  ec;
    bit          fin;
    ec = exp_chs;
    if (stray) begin
      sample_ack = 1'b1;
      @(negedge clk);
      sample_ack = 1'b0;
      chk("idle_ack_busy", busy, 0);
      chk("idle_ack_req", sample_req, 0);
    end
    ch_mask = m;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    ch_mask = 4'($urandom);
    if (exp_n == 0) begin
      repeat (3) begin
        chk("zero_mask_busy", busy, 0);
        chk("zero_mask_req", sample_req, 0);
        @(negedge clk);
      end
      return;
    end
    chk("start_busy", busy, 1);
    chk("first_ch", ch_sel, ec[1:0]);
    ord = 0;
    fin = 1'b0;
    while (!fin) begin
      held = ch_sel;
      low  = 0;
      while (!sample_req && low < 20) begin
        chk("settle_ch_stable", ch_sel, held);
        chk("settle_busy", busy, 1);
        sample_ack = stray && (low == 0);
        start      = stray && (low == 0);
        low++;
        @(negedge clk);
      end
      sample_ack = 1'b0;
      start      = 1'b0;
      chk("settle_len", low, 3);
      got_q.push_back(32'(ch_sel));
      repeat (dly) begin
        chk("req_held", sample_req, 1);
        chk("req_ch_stable", ch_sel, held);
        @(negedge clk);
      end
      sample_ack = 1'b1;
      if (abort_mode == 1 && ord == abort_ord) begin
        abort = 1'b1;
        @(negedge clk);
        abort      = 1'b0;
        sample_ack = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_req", sample_req, 0);
        repeat (3) begin
          chk("abort_no_done", done, 0);
          chk("abort_count", scan_count, exp_count);
          @(negedge clk);
        end
        chk("abort_n_samples", got_q.size(), abort_ord + 1);
        for (int i = 0; i < got_q.size() && i < 4; i++)
          chk("abort_sample_ch", got_q[i], 32'(ec[2*i +: 2]));
        return;
      end
      @(negedge clk);
      sample_ack = 1'b0;
      ord++;
      if (done) fin = 1'b1;
      else if (ord >= 8) begin
        chk("scan_terminates", ord, exp_n);
        fin = 1'b1;
      end
    end
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_req", sample_req, 0);
    chk("count_in_done", scan_count, exp_count);
    if (abort_mode == 2) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end else begin
      @(negedge clk);
      exp_count = exp_count + 4'd1;
    end
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_count", scan_count, exp_count);
    chk("n_samples", got_q.size(), exp_n);
    lim = (got_q.size() < exp_n) ? got_q.size() : exp_n;
    for (int i = 0; i < lim && i < 4; i++)
      chk("sample_ch", got_q[i], 32'(ec[2*i +: 2]));
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[$];
    logic [7:0]  rc;
    int unsigned rn, am, ao;
    logic [3:0]  rm;

    vecs.push_back('{4'b1111, 1, 1'b0, 0, 0, 8'b11_10_01_00, 4});
    vecs.push_back('{4'b1010, 0, 1'b1, 0, 0, 8'b00_00_11_01, 2});
    vecs.push_back('{4'b0000, 0, 1'b0, 0, 0, 8'h00, 0});
    vecs.push_back('{4'b0001, 5, 1'b1, 0, 0, 8'h00, 1});
    vecs.push_back('{4'b1111, 0, 1'b0, 1, 2, 8'b11_10_01_00, 4});
    vecs.push_back('{4'b1000, 2, 1'b0, 2, 0, 8'b00_00_00_11, 1});
    vecs.push_back('{4'b0110, 3, 1'b0, 0, 0, 8'b00_00_10_01, 2});

    repeat (2) @(negedge clk);
    chk("rst_ch_sel", ch_sel, 0);
    chk("rst_req", sample_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", scan_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      do_scan(vecs[i].mask, vecs[i].dly, vecs[i].stray, vecs[i].abort_mode,
              vecs[i].abort_ord, vecs[i].exp_chs, vecs[i].exp_n);

    for (int r = 0; r < 24; r++) begin
      rm = 4'($urandom_range(0, 15));
      ref_chs(rm, rc, rn);
      am = 0;
      ao = 0;
      if (rn > 0) begin
        am = $urandom_range(0, 5);
        am = (am == 0) ? 1 : (am == 1) ? 2 : 0;
        ao = $urandom_range(0, rn - 1);
      end
      do_scan(rm, $urandom_range(0, 3), 1'($urandom_range(0, 1)), am, ao, rc, rn);
    end

    // Reset in the middle of a scan on channel 2.
    ch_mask = 4'b1100;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_ch", ch_sel, 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ch_sel", ch_sel, 0);
    chk("midrst_req", sample_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_count", scan_count, 0);
    rst_n     = 1'b1;
    exp_count = '0;
    @(negedge clk);

    repeat (17) do_scan(4'b0001, 0, 1'b0, 0, 0, 8'h00, 1);
    chk("wrap_count", scan_count, 1);

    // Zero settle build: request stays high while the channel advances.
    z_mask  = 4'b0111;
    z_start = 1'b1;
    @(negedge clk);
    z_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("z_req_high", z_req, 1);
      chk("z_ch", z_ch, i);
      chk("z_done_low", z_done, 0);
      z_ack = 1'b1;
      @(negedge clk);
    end
    z_ack = 1'b0;
    chk("z_done", z_done, 1);
    chk("z_req_low", z_req, 0);
    @(negedge clk);
    chk("z_done_once", z_done, 0);
    chk("z_busy", z_busy, 0);
    chk("z_count", z_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
# scan_sequencer

Controller that sequences a shared sensor/feature front-end by stepping through a programmable set of input channels. For each channel it waits a fixed settle time, counted by an internal cycle counter, then performs a req/ack sample handshake. It sits between the system start logic and the shared sampling datapath (mux + ADC/feature unit), in the same low-frequency flexible-electronics flow as the other hw_eval designs (nominal CLK_PERIOD 1000 ns).

## Interface
- NUM_CH, 4, number of selectable channels (≥2)
- CH_W, $clog2(NUM_CH), width of channel index
- SETTLE_CYCLES, 3, settle cycles per channel before sampling (0 allowed)
- CNT_W, 4, width of completed-scan counter
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  request a scan; accepted only in IDLE with nonzero ch_mask
- abort  in  1  terminate scan; honoured in any non-IDLE state
- ch_mask  in  NUM_CH  channels to scan, bit i = channel i; latched on start acceptance
- ch_sel  out  CH_W  channel currently selected on the shared datapath
- sample_req  out  1  sample request to datapath, held until acknowledged
- sample_ack  in  1  datapath completion; meaningful only while sample_req=1
- busy  out  1  high in SETTLE, SAMPLE, DONE
- done  out  1  one-cycle pulse after the last channel of a scan is sampled
- scan_count  out  CNT_W  completed (non-aborted) scans, wraps modulo 2^CNT_W

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: if start && ch_mask!=0, latch mask, ch_sel := lowest set bit, clear timer, go to SETTLE; if SETTLE_CYCLES==0, go directly to SAMPLE. start with ch_mask==0 is ignored.
- SETTLE: timer increments each cycle. When timer==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE: sample_req=1. On sample_ack:
  - if a higher set bit exists in the latched mask, ch_sel := next set bit, timer cleared, go to SETTLE (or SAMPLE if SETTLE_CYCLES==0);
  - otherwise go to DONE.
- DONE: done=1 and scan_count increments, both for exactly one cycle; then IDLE.
- abort: from SETTLE/SAMPLE/DONE, go to IDLE next cycle. No done pulse and no scan_count increment, including an abort sampled in DONE. abort has priority over sample_ack and over timer expiry.
- start outside IDLE is ignored; no queuing.
- sample_ack outside SAMPLE is ignored.
- Changes to ch_mask mid-scan have no effect.
- ch_sel holds its last value in IDLE.
- Reset values: ch_sel=0, sample_req=0, busy=0, done=0, scan_count=0, state IDLE, timer 0, latched mask 0. Reset mid-scan returns to IDLE on that edge with these values; scan_count is also cleared.

## Timing
- start sampled at edge k → state/busy/ch_sel valid after edge k; sample_req rises after edge k+SETTLE_CYCLES.
- ch_sel is stable for the whole SETTLE+SAMPLE of a channel. It changes only on the edge that accepts ack.
- Handshake: sample_req registered. Transfer on the edge where sample_req&&sample_ack. sample_req drops after that edge, so there is no back-to-back req across channels: at least SETTLE_CYCLES low cycles, or 0 low cycles when SETTLE_CYCLES==0. In that case req stays high and ch_sel advances.
- Ack accepted for the last channel at edge m → done=1 in cycle after m. busy falls and a new start is accepted from edge m+2.
- All outputs are registered or decoded from state only; no input-to-output combinational path.

## Structure
- Package scan_seq_pkg: state enum (IDLE, SETTLE, SAMPLE, DONE) and a next-set-bit priority function over NUM_CH.
- Sub-module seq_timer: settle counter with clr/en and terminal-count output, width $clog2(SETTLE_CYCLES+1). It is instantiated once. The rest (FSM, mask register, ch_sel, scan_count) lives in the top.

## Test plan
- Reset, then full scan: NUM_CH=4, SETTLE_CYCLES=3, mask=4'b1111, ack one cycle after each req → ch_sel 0,1,2,3. Each req rises 3 cycles after channel entry, followed by one done pulse, scan_count=1, busy low 2 cycles after last ack.
- Sparse mask 4'b1010 → only channels 1 then 3 sampled. mask=0 with start → busy stays 0, no req.
- Ack delayed 5 cycles → sample_req held high 5 cycles and ch_sel stable. Ack pulsed in SETTLE/IDLE → ignored.
- abort in SAMPLE on channel 2 together with sample_ack → IDLE next cycle, no done, scan_count unchanged. A new start is accepted afterwards.
- SETTLE_CYCLES=0 build, mask 4'b0111 → sample_req continuously high across 3 acks, ch_sel 0→1→2, done once.
- 17 back-to-back scans (CNT_W=4) → scan_count wraps to 1. rst_n low mid-scan → all outputs at reset values on the next edge.
